// File: rtl/reduction_unit.sv
// rtl/reduction_unit.sv - registered byte-lane reduction adder, result sign-extended from bit 8
module reduction_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        in_valid,
  output logic [15:0] S,
  output logic        out_valid
);

  // 4-bit carry-lookahead block; returns {carry_out, sum[3:0]}
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] pp;
    logic [3:0] gg;
    logic [4:0] c;
    pp   = a ^ b;
    gg   = a & b;
    c[0] = cin;
    c[1] = gg[0] | (pp[0] & c[0]);
    c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
    c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c[0]);
    c[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
         | (pp[3] & pp[2] & pp[1] & pp[0] & c[0]);
    return {c[4], pp ^ c[3:0]};
  endfunction

  logic [4:0]  e_lo, e_hi, f_lo, f_hi, g_lo, g_mid;
  logic [8:0]  e, f, g;
  logic [15:0] result;
  logic [15:0] s_d, s_q;
  logic        out_valid_d, out_valid_q;

  always_comb begin
    e_lo  = cla4(A[3:0], B[3:0], 1'b0);
    e_hi  = cla4(A[7:4], B[7:4], e_lo[4]);
    e     = {e_hi, e_lo[3:0]};
    f_lo  = cla4(A[11:8], B[11:8], 1'b0);
    f_hi  = cla4(A[15:12], B[15:12], f_lo[4]);
    f     = {f_hi, f_lo[3:0]};
    g_lo  = cla4(e[3:0], f[3:0], 1'b0);
    g_mid = cla4(e[7:4], f[7:4], g_lo[4]);
    // Top bit of the 9-bit sum; its carry out wraps away
    g      = {e[8] ^ f[8] ^ g_mid[4], g_mid[3:0], g_lo[3:0]};
    result = {{7{g[8]}}, g};

    s_d         = s_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      s_d         = result;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign S         = s_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_reduction_unit.sv
// tb/tb_reduction_unit.sv - randomized self-checking bench for reduction_unit
module tb_reduction_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        in_valid;
  logic [15:0] S;
  logic        out_valid;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_s;

  reduction_unit dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid),
    .S(S), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Sum of all four bytes, wrapped to 9 bits, read as a 9-bit signed value
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    int sum;
    sum = int'(a[7:0]) + int'(b[7:0]) + int'(a[15:8]) + int'(b[15:8]);
    sum = sum % 512;
    if (sum >= 256) sum = sum - 512;
    return 16'(sum);
  endfunction

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic v);
    @(negedge clk);
    A = a; B = b; in_valid = v;
    if (v) exp_s = model(a, b);
    @(posedge clk);
    #1;
    check({tag, "_s"}, S, exp_s);
    check({tag, "_valid"}, {15'b0, out_valid}, {15'b0, v});
  endtask

  initial begin
    rst_n = 1'b0; A = 16'h0; B = 16'h0; in_valid = 1'b0; exp_s = 16'h0;
    #12;
    check("reset_s", S, 16'h0000);
    check("reset_valid", {15'b0, out_valid}, 16'h0);
    @(negedge clk); rst_n = 1'b1;

    op("load", 16'h1234, 16'h5678, 1'b1);
    // Reset mid-cycle clears the register with no edge
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_s", S, 16'h0000);
    check("async_rst_valid", {15'b0, out_valid}, 16'h0);
    exp_s = 16'h0;
    @(negedge clk); rst_n = 1'b1;

    op("first", 16'h0101, 16'h0101, 1'b1);
    check("first_const", S, 16'h0004);
    op("allff", 16'hFFFF, 16'hFFFF, 1'b1);
    check("allff_const", S, 16'hFFFC);
    op("sext", 16'h7F7F, 16'h0101, 1'b1);
    check("sext_const", S, 16'hFF00);
    op("wrap0", 16'h80FF, 16'h8001, 1'b1);
    check("wrap0_const", S, 16'h0000);

    op("pre_hold", 16'h0203, 16'h0405, 1'b1);
    op("hold", 16'hFFFF, 16'h7777, 1'b0);
    check("hold_const", S, 16'h000E);
    // Inputs changed between edges must not leak into S
    @(negedge clk); A = 16'hAAAA; B = 16'h5555; in_valid = 1'b0;
    #2; A = 16'h1111;
    @(posedge clk); #1;
    check("between_edges", S, exp_s);

    op("b2b_a", 16'h0010, 16'h0020, 1'b1);
    op("b2b_b", 16'hF00F, 16'h0FF0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      logic [15:0] ra, rb;
      logic rv;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rv = ($urandom_range(0, 9) != 0);
      op("rand", ra, rb, rv);
      if (errors != 0) break;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
